dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder_pkg.sv | 27 ++
 rtl/dmem_array.sv | 30 +++
 rtl/dmem_responder.sv | 117 +++++++++++
 tb/tb_dmem_responder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM state enum, lane/word-address widths and a byte-lane helper.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  localparam int LANE_W  = 8;
  localparam int WADDR_W = 10;

  // Pick one byte lane out of a word and widen it to 32 bits.
  function automatic logic [31:0] lane_ext(
    input logic [31:0] word,
    input logic [1:0]  lane,
    input logic        sgn
  );
    logic [31:0] sh;
    logic [7:0]  b;
    sh = word >> {lane, 3'b000};
    b  = sh[LANE_W-1:0];
    return sgn ? {{24{b[7]}}, b} : {24'b0, b};
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage: DEPTH_WORDS x 32, byte-enabled sync write.
// Ports: clk, we, be[3:0], addr (word index), wdata in; rdata (comb) out.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic               clk,
  input  logic               we,
  input  logic [3:0]         be,
  input  logic [WADDR_W-1:0] addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request in, fixed-latency response out.
// Ports: clk, reset; req_valid/ready/we/byte/signed/addr/wdata;
// rsp_valid/ready/rdata/err. Storage lives in dmem_array.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_byte,
  input  logic        req_signed,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  state_t      state;
  logic [3:0]  cnt;
  logic        l_we;
  logic        l_byte;
  logic        l_signed;
  logic [11:0] l_addr;
  logic [31:0] l_wdata;

  logic [31:0]        idx_full;
  logic [WADDR_W-1:0] idx;
  logic               misalign;
  logic               last;
  logic               mem_we;
  logic [3:0]         mem_be;
  logic [31:0]        mem_wdata;
  logic [31:0]        mem_rdata;
  logic [31:0]        load_data;

  assign idx_full = 32'(l_addr[11:2]) % 32'(DEPTH_WORDS);
  assign idx      = idx_full[WADDR_W-1:0];
  assign misalign = !l_byte && (l_addr[1:0] != 2'b00);
  assign last     = (state == BUSY) && (cnt == 4'd0);

  // Reset wins over a commit landing on the same edge.
  assign mem_we    = last && l_we && !misalign && !reset;
  assign mem_be    = l_byte ? (4'b0001 << l_addr[1:0]) : 4'hF;
  assign mem_wdata = l_byte ? {4{l_wdata[7:0]}} : l_wdata;

  always_comb begin
    load_data = 32'd0;
    if (!l_we && !misalign) begin
      load_data = l_byte ? lane_ext(mem_rdata, l_addr[1:0], l_signed)
                         : mem_rdata;
    end
  end

  assign req_ready = (state == IDLE) && !reset;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .be   (mem_be),
    .addr (idx),
    .wdata(mem_wdata),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            l_we     <= req_we;
            l_byte   <= req_byte;
            l_signed <= req_signed;
            l_addr   <= req_addr;
            l_wdata  <= req_wdata;
            cnt      <= 4'(WAIT_CYCLES);
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= load_data;
            rsp_err   <= misalign;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed and random accesses vs. a memory model.
// Second instance with WAIT_CYCLES=0 exercises back-to-back throughput.
module tb_dmem_responder;

  localparam int W = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid, req_ready, req_we, req_byte, req_signed;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  logic        req_valid0, req_ready0, req_we0, req_byte0, req_signed0;
  logic [11:0] req_addr0;
  logic [31:0] req_wdata0;
  logic        rsp_valid0, rsp_ready0, rsp_err0;
  logic [31:0] rsp_rdata0;

  dmem_responder #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_byte(req_byte), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid0), .req_ready(req_ready0),
    .req_we(req_we0), .req_byte(req_byte0), .req_signed(req_signed0),
    .req_addr(req_addr0), .req_wdata(req_wdata0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
    .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
  );

  int nvec = 0;
  int nmis = 0;
  int cyc  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference memory: [0] mirrors dut, [1] mirrors dut0.
  logic [31:0] mm [2][1024];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void ref_op(input int sel, input logic we,
      input logic bt, input logic sgn, input logic [11:0] a,
      input logic [31:0] wd, output logic [31:0] rd, output logic err);
    int idx;
    int sh;
    logic [7:0] b;
    idx = int'(a[11:2]);
    sh  = int'(a[1:0]) * 8;
    rd  = 32'd0;
    err = 1'b0;
    if (!bt && a[1:0] != 2'b00) begin
      err = 1'b1;
    end else if (we) begin
      if (bt) mm[sel][idx][sh +: 8] = wd[7:0];
      else    mm[sel][idx] = wd;
    end else if (bt) begin
      b  = mm[sel][idx][sh +: 8];
      rd = sgn ? {{24{b[7]}}, b} : {24'd0, b};
    end else begin
      rd = mm[sel][idx];
    end
  endfunction

  task automatic do_req(input logic we, input logic bt, input logic sgn,
      input logic [11:0] a, input logic [31:0] wd, input int hold,
      input string tag);
    logic [31:0] er;
    logic        e;
    int          n;
    ref_op(0, we, bt, sgn, a, wd, er, e);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_byte = bt;
    req_signed = sgn; req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk({tag, " ready"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_byte = 1'($urandom);
    req_signed = 1'($urandom); req_addr = 12'($urandom);
    req_wdata = $urandom;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 20);
    chk({tag, " latency"}, 32'(n), 32'(W + 2));
    chk({tag, " rdata"}, rsp_rdata, er);
    chk({tag, " err"}, 32'(rsp_err), 32'(e));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk({tag, " hold valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, " hold rdata"}, rsp_rdata, er);
      chk({tag, " hold ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, " rsp drop"}, 32'(rsp_valid), 32'd0);
    chk({tag, " idle ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] er;
    logic        e;
    int          n;
    int          prev;
    logic        we, bt, sgn;
    logic [11:0] a;

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_byte = 1'b0;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    req_valid0 = 1'b0; req_we0 = 1'b0; req_byte0 = 1'b0;
    req_signed0 = 1'b0; req_addr0 = '0; req_wdata0 = '0; rsp_ready0 = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset ready", 32'(req_ready), 32'd0);
    chk("reset valid", 32'(rsp_valid), 32'd0);
    chk("reset rdata", rsp_rdata, 32'd0);
    chk("reset err", 32'(rsp_err), 32'd0);
    reset = 1'b0; #1;
    chk("post-reset ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 64; i++)
      do_req(1'b1, 1'b0, 1'b0, 12'(i * 4), $urandom, 0, "init");

    do_req(1'b1, 1'b0, 1'b0, 12'h010, 32'h12345678, 0, "sw010");
    do_req(1'b0, 1'b0, 1'b0, 12'h010, 32'h0, 0, "lw010");
    do_req(1'b1, 1'b1, 1'b0, 12'h013, 32'h000000AB, 0, "sb013");
    do_req(1'b0, 1'b1, 1'b1, 12'h013, 32'h0, 0, "lb013");
    do_req(1'b0, 1'b1, 1'b0, 12'h013, 32'h0, 0, "lbu013");
    do_req(1'b0, 1'b0, 1'b0, 12'h010, 32'h0, 0, "lw010b");
    do_req(1'b0, 1'b0, 1'b0, 12'h012, 32'h0, 0, "lw012 mis");
    do_req(1'b1, 1'b0, 1'b0, 12'h016, 32'hCAFEF00D, 0, "sw016 mis");
    do_req(1'b0, 1'b0, 1'b0, 12'h014, 32'h0, 0, "lw014");
    do_req(1'b0, 1'b0, 1'b0, 12'h010, 32'h0, 5, "hold5");

    // Store aborted by reset in its final BUSY cycle.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b0;
    req_addr = 12'h020; req_wdata = 32'hDEADBEEF;
    chk("abort ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (W + 1) @(negedge clk);
    reset = 1'b1; #1;
    chk("abort reset ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0; #1;
    chk("abort after ready", 32'(req_ready), 32'd1);
    n = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rsp_valid) n++;
    end
    chk("abort no rsp", 32'(n), 32'd0);
    do_req(1'b0, 1'b0, 1'b0, 12'h020, 32'h0, 0, "lw020 old");

    for (int i = 0; i < 60; i++) begin
      we  = 1'($urandom);
      bt  = 1'($urandom);
      sgn = 1'($urandom);
      a   = 12'($urandom_range(0, 255));
      do_req(we, bt, sgn, a, $urandom, int'($urandom_range(0, 2)), "rand");
    end

    // Zero-wait instance: back-to-back stream, response always accepted.
    rsp_ready0 = 1'b1;
    prev = 0;
    @(negedge clk);
    req_valid0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      unique case (i)
        0: begin we = 1; bt = 0; sgn = 0; a = 12'h000; end
        1: begin we = 1; bt = 0; sgn = 0; a = 12'h004; end
        2: begin we = 1; bt = 0; sgn = 0; a = 12'h008; end
        3: begin we = 1; bt = 1; sgn = 0; a = 12'h005; end
        4: begin we = 0; bt = 0; sgn = 0; a = 12'h000; end
        5: begin we = 0; bt = 1; sgn = 1; a = 12'h005; end
        6: begin we = 0; bt = 0; sgn = 0; a = 12'h004; end
        default: begin we = 0; bt = 0; sgn = 0; a = 12'h008; end
      endcase
      req_we0 = we; req_byte0 = bt; req_signed0 = sgn;
      req_addr0 = a; req_wdata0 = $urandom;
      n = 0;
      while (!req_ready0 && n < 10) begin @(negedge clk); n++; end
      chk("b2b ready", 32'(req_ready0), 32'd1);
      if (i > 0) chk("b2b spacing", 32'(cyc - prev), 32'd3);
      prev = cyc;
      ref_op(1, we, bt, sgn, a, req_wdata0, er, e);
      @(negedge clk);
      chk("b2b busy", 32'(rsp_valid0), 32'd0);
      @(negedge clk);
      chk("b2b valid", 32'(rsp_valid0), 32'd1);
      chk("b2b rdata", rsp_rdata0, er);
      chk("b2b err", 32'(rsp_err0), 32'(e));
    end
    req_valid0 = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
